// File: rtl/id_pipe_if.sv
// Upstream/downstream valid-ready bundle for id_pipe.
// Carries inst/inst_addr in; out_valid/out_ready out.
interface id_pipe_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       inst;
  logic [DATA_W-1:0] inst_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_valid, inst, inst_addr, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, inst, inst_addr, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/id_pipe.sv
// Decode stage: holds one instruction, decodes fields, forwards operands,
// resolves jump/branch targets. Ports: clk, rst_n, bus (valid/ready),
// flush, qualifiers, fwd_{a,b}_{data,sel}, decoded outputs, stall_cnt.
module id_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16,
  localparam int SEL_W =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  id_pipe_if.slave                    bus,
  input  logic                        flush,
  input  logic                        reg_rt,
  input  logic                        sext_signed,
  input  logic [1:0]                  jump,
  input  logic [2:0]                  cmp_mode,
  input  logic [NUM_PORTS*DATA_W-1:0] fwd_a_data,
  input  logic [NUM_PORTS*DATA_W-1:0] fwd_b_data,
  input  logic [SEL_W-1:0]            fwd_a_sel,
  input  logic [SEL_W-1:0]            fwd_b_sel,
  output logic [5:0]                  opcode,
  output logic [4:0]                  rs,
  output logic [4:0]                  rt,
  output logic [5:0]                  func,
  output logic [4:0]                  reg_des,
  output logic [DATA_W-1:0]           imm_ext,
  output logic [DATA_W-1:0]           op_a,
  output logic [DATA_W-1:0]           op_b,
  output logic [DATA_W-1:0]           jump_addr,
  output logic [DATA_W-1:0]           link_addr,
  output logic                        br_taken,
  output logic [CNT_W-1:0]            stall_cnt
);

  logic              valid_q;
  logic [31:0]       inst_q;
  logic [DATA_W-1:0] addr_q;
  logic              take;
  logic              stall;

  assign bus.out_valid = valid_q;
  assign bus.in_ready  =
    (!valid_q || bus.out_ready) && !flush;

  assign take  = bus.in_valid && bus.in_ready;
  assign stall = valid_q && !bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      addr_q    <= '0;
      link_addr <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (take) begin
      valid_q   <= 1'b1;
      inst_q    <= bus.inst;
      addr_q    <= bus.inst_addr;
      link_addr <= bus.inst_addr;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Saturating: holds at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign opcode  = inst_q[31:26];
  assign rs      = inst_q[25:21];
  assign rt      = inst_q[20:16];
  assign func    = inst_q[5:0];
  assign reg_des = reg_rt ? inst_q[20:16] : inst_q[15:11];

  logic [DATA_W-1:0] imm_sx;
  logic [DATA_W-1:0] imm_zx;

  assign imm_sx =
    {{(DATA_W-16){inst_q[15]}}, inst_q[15:0]};
  assign imm_zx = {{(DATA_W-16){1'b0}}, inst_q[15:0]};
  assign imm_ext = sext_signed ? imm_sx : imm_zx;

  // Out-of-range selects match no port and fall to port 0
  always_comb begin
    op_a = fwd_a_data[DATA_W-1:0];
    op_b = fwd_b_data[DATA_W-1:0];
    for (int k = 1; k < NUM_PORTS; k++) begin
      if (fwd_a_sel == SEL_W'(k))
        op_a = fwd_a_data[k*DATA_W +: DATA_W];
      if (fwd_b_sel == SEL_W'(k))
        op_b = fwd_b_data[k*DATA_W +: DATA_W];
    end
  end

  logic [DATA_W-1:0] j_tgt;
  logic [DATA_W-1:0] b_tgt;

  always_comb begin
    j_tgt = '0;
    j_tgt[DATA_W-1 -: 4] = addr_q[DATA_W-1 -: 4];
    j_tgt[27:0] = {inst_q[25:0], 2'b00};
  end

  assign b_tgt = addr_q + (imm_sx << 2);

  always_comb begin
    unique case (jump)
      2'd1:    jump_addr = j_tgt;
      2'd2:    jump_addr = b_tgt;
      2'd3:    jump_addr = op_a;
      default: jump_addr = '0;
    endcase
  end

  logic a_neg;
  logic a_zero;
  logic cond;

  assign a_neg  = op_a[DATA_W-1];
  assign a_zero = (op_a == '0);

  always_comb begin
    unique case (cmp_mode)
      3'd0:    cond = (op_a == op_b);
      3'd1:    cond = (op_a != op_b);
      3'd2:    cond = a_neg;
      3'd3:    cond = !a_neg;
      3'd4:    cond = !a_neg && !a_zero;
      3'd5:    cond = a_neg || a_zero;
      default: cond = 1'b0;
    endcase
  end

  assign br_taken = valid_q &&
    ((jump == 2'd2 && cond) ||
     jump == 2'd1 || jump == 2'd3);

endmodule
